// File: rtl/pathfinding_pkg.sv
// Shared types for the pathfinding pipeline: node records, path elements,
// error codes. Optional build macro used by path_backtrack: BACKTRACK_TIMEOUT_EN.
package pathfinding_pkg;

    typedef struct packed {
        logic [15:0] node_id;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] cost;
    } map_node;

    // 272-bit node record produced by the search stage
    typedef struct packed {
        logic [15:0]       node_id;
        logic [15:0]       x;
        logic [15:0]       y;
        logic [15:0]       parent_id;
        logic [31:0]       g_cost;
        logic [31:0]       h_cost;
        logic [31:0]       f_cost;
        logic [3:0][15:0]  neighbors;
        logic [47:0]       flags;
    } node_info;

    typedef struct packed {
        logic [15:0] id;
        logic [15:0] x;
        logic [15:0] y;
    } path_elem;

    localparam logic [15:0] NODE_ID_NULL  = 16'd0;

    localparam logic [1:0]  ERR_NONE      = 2'd0;
    localparam logic [1:0]  ERR_NOT_FOUND = 2'd1;
    localparam logic [1:0]  ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0]  ERR_TIMEOUT   = 2'd3;

    function automatic path_elem to_elem(input node_info n);
        path_elem e;
        e.id = n.node_id;
        e.x  = n.x;
        e.y  = n.y;
        return e;
    endfunction

endpackage

// File: rtl/path_stack.sv
// LIFO of path elements with combinational top-of-stack read.
module path_stack
    import pathfinding_pkg::*;
#(
    parameter int MAX_PATH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  path_elem                   push_data,
    output path_elem                   top,
    output logic [$clog2(MAX_PATH):0]  count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW   = $clog2(MAX_PATH);
    localparam int SP_W = AW + 1;

    path_elem         mem [MAX_PATH];
    logic [SP_W-1:0]  top_idx;

    // storage and stack pointer; a full stack refuses further pushes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            for (int i = 0; i < MAX_PATH; i++) mem[i] <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (push && !full) begin
            mem[count[AW-1:0]] <= push_data;
            count              <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

    assign full    = (count == SP_W'(MAX_PATH));
    assign empty   = (count == '0);
    assign top_idx = count - 1'b1;
    assign top     = mem[top_idx[AW-1:0]];

endmodule

// File: rtl/path_backtrack.sv
// Walks parent links from the goal back to the start node through the parent
// finder, stacks each node, then streams the path start-to-goal.
// Optional build macro: BACKTRACK_TIMEOUT_EN (per-lookup watchdog, err_code 3).
//
// state  | meaning
// IDLE   | waiting for start
// PUSH   | stack current node, decide finish / overflow / next lookup
// REQ    | pf_find pulse with current node
// WAIT   | waiting for the parent finder
// EMIT   | streaming stacked nodes, top first
// DONE   | done pulse, stack cleared
module path_backtrack
    import pathfinding_pkg::*;
#(
    parameter int MAX_PATH       = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  node_info    goal_node,
    input  logic [15:0] start_node_id,
    output logic        pf_find,
    output node_info    pf_current_node,
    input  node_info    pf_parent_node,
    input  logic        pf_done,
    output logic        path_valid,
    input  logic        path_ready,
    output logic [15:0] path_node_id,
    output logic [15:0] path_x,
    output logic [15:0] path_y,
    output logic        path_last,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code
);

    localparam int SP_W = $clog2(MAX_PATH) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PUSH, S_REQ, S_WAIT, S_EMIT, S_DONE
    } state_t;

    state_t           state;
    node_info         cur;
    logic [15:0]      start_id;
    logic [SP_W-1:0]  sp;
    path_elem         top_elem;
    logic             stk_full;
    logic             stk_empty;
    logic             push;
    logic             pop;
    logic             clear;

`ifdef BACKTRACK_TIMEOUT_EN
    logic [15:0]      wd_cnt;
`endif

    assign push  = (state == S_PUSH);
    assign pop   = (state == S_EMIT) && path_valid && path_ready && !stk_empty;
    assign clear = (state == S_DONE);

    path_stack #(.MAX_PATH(MAX_PATH)) u_stack (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .push      (push),
        .pop       (pop),
        .push_data (to_elem(cur)),
        .top       (top_elem),
        .count     (sp),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // path data is taken straight from the stack top while presenting
    assign path_node_id = path_valid ? top_elem.id : '0;
    assign path_x       = path_valid ? top_elem.x  : '0;
    assign path_y       = path_valid ? top_elem.y  : '0;
    assign path_last    = path_valid && (sp == SP_W'(1));

    // sequencing FSM with registered handshake and status outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            cur             <= '0;
            start_id        <= '0;
            pf_find         <= 1'b0;
            pf_current_node <= '0;
            path_valid      <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_code        <= ERR_NONE;
`ifdef BACKTRACK_TIMEOUT_EN
            wd_cnt          <= '0;
`endif
        end else begin
            pf_find <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cur      <= goal_node;
                        start_id <= start_node_id;
                        err_code <= ERR_NONE;
                        busy     <= 1'b1;
                        state    <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (cur.node_id == start_id) begin
                        path_valid <= 1'b1;
                        state      <= S_EMIT;
                    end else if ((sp + 1'b1) == SP_W'(MAX_PATH)) begin
                        err_code <= ERR_OVERFLOW;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        pf_find         <= 1'b1;
                        pf_current_node <= cur;
                        state           <= S_REQ;
                    end
                end
                S_REQ: begin
`ifdef BACKTRACK_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (pf_done) begin
                        if (pf_parent_node.node_id == NODE_ID_NULL) begin
                            err_code <= ERR_NOT_FOUND;
                            done     <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            cur   <= pf_parent_node;
                            state <= S_PUSH;
                        end
                    end
`ifdef BACKTRACK_TIMEOUT_EN
                    else if ((wd_cnt + 16'd1) == 16'(TIMEOUT_CYCLES)) begin
                        err_code <= ERR_TIMEOUT;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
                    end
`endif
                end
                S_EMIT: begin
                    if (path_valid && path_ready && (sp == SP_W'(1))) begin
                        path_valid <= 1'b0;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // full flag is implied by the sp+1 overflow check; watchdog limit only used with the option
    logic unused_ok;
`ifdef BACKTRACK_TIMEOUT_EN
    assign unused_ok = stk_full;
`else
    assign unused_ok = ^{stk_full, TIMEOUT_CYCLES[0]};
`endif

endmodule

// File: tb/tb_path_backtrack.sv
// Directed bench for path_backtrack: vector table of complete walks plus
// hand-written reset-mid-walk and (optional) watchdog sequences.
module tb_path_backtrack;
    import pathfinding_pkg::*;

    localparam int MAX_PATH = 64;
    localparam int TOUT     = 16;
    localparam int FIND_LAT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    node_info    goal_node = '0;
    logic [15:0] start_node_id = '0;
    logic        pf_find;
    node_info    pf_current_node;
    node_info    pf_parent_node = '0;
    logic        pf_done = 1'b0;
    logic        path_valid;
    logic        path_ready = 1'b1;
    logic [15:0] path_node_id, path_x, path_y;
    logic        path_last, busy, done;
    logic [1:0]  err_code;

    path_backtrack #(.MAX_PATH(MAX_PATH), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .reset(reset), .start(start), .goal_node(goal_node),
        .start_node_id(start_node_id), .pf_find(pf_find),
        .pf_current_node(pf_current_node), .pf_parent_node(pf_parent_node),
        .pf_done(pf_done), .path_valid(path_valid), .path_ready(path_ready),
        .path_node_id(path_node_id), .path_x(path_x), .path_y(path_y),
        .path_last(path_last), .busy(busy), .done(done), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int mode = 0;          // 0 table, 1 null parent, 2 chain id-1, 3 silent
    bit ready_toggle = 1'b0;
    int pf_find_cnt = 0;
    int done_cnt = 0;
    int unstable = 0;
    int find_cyc = 0;
    int done_cyc = 0;
    bit valid_seen = 1'b0;
    logic [15:0] got_id[$];
    logic [15:0] got_x[$];
    logic [15:0] got_y[$];
    logic        got_last[$];

    typedef struct {
        string       name;
        logic [15:0] goal;
        logic [15:0] sid;
        int          mode;
        bit          toggle;
        bit          poke;
        logic [1:0]  err;
        int          len;
        int          finds;
        logic [15:0] ids [4];
    } vec_t;

    vec_t vecs [5];

    function automatic node_info mk(input logic [15:0] id);
        node_info n;
        n = '0;
        n.node_id = id;
        n.x       = id * 16'd2 + 16'd100;
        n.y       = id * 16'd3 + 16'd7;
        n.g_cost  = 32'(id) + 32'd11;
        return n;
    endfunction

    function automatic logic [15:0] parent_of(input logic [15:0] id);
        if (mode == 2) return id - 16'd1;
        if (mode == 1) return 16'd0;
        case (id)
            16'd5:   return 16'd3;
            16'd3:   return 16'd1;
            default: return 16'd0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // parent finder model: answers FIND_LAT cycles after the pf_find pulse
    initial begin
        logic [15:0] rid;
        forever begin
            @(posedge clk); #1;
            if (pf_find === 1'b1) begin
                pf_find_cnt++;
                find_cyc = cyc;
                rid = pf_current_node.node_id;
                if (mode != 3) begin
                    repeat (FIND_LAT - 1) @(posedge clk);
                    #1;
                    pf_parent_node = (parent_of(rid) == 16'd0) ? node_info'('0) : mk(parent_of(rid));
                    pf_done = 1'b1;
                    @(posedge clk); #1;
                    pf_done = 1'b0;
                    pf_parent_node = '0;
                end
            end
        end
    end

    // consumer ready: constant 1 or toggling every cycle
    initial begin
        forever begin
            @(posedge clk); #1;
            path_ready = ready_toggle ? ~path_ready : 1'b1;
        end
    end

    // stream monitor: accepted elements, done pulses, stability while stalled
    initial begin
        bit hold = 1'b0;
        logic [15:0] pid = '0, px = '0, py = '0;
        logic pl = 1'b0;
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (path_valid) valid_seen = 1'b1;
            if (hold && (!path_valid || path_node_id !== pid || path_x !== px ||
                         path_y !== py || path_last !== pl))
                unstable++;
            if (path_valid && path_ready) begin
                got_id.push_back(path_node_id);
                got_x.push_back(path_x);
                got_y.push_back(path_y);
                got_last.push_back(path_last);
            end
            hold = path_valid && !path_ready;
            pid = path_node_id; px = path_x; py = path_y; pl = path_last;
        end
    end

    task automatic run_walk(input vec_t v);
        bit seen;
        node_info en;
        mode = v.mode;
        ready_toggle = v.toggle;
        got_id.delete(); got_x.delete(); got_y.delete(); got_last.delete();
        pf_find_cnt = 0; done_cnt = 0; unstable = 0; valid_seen = 1'b0;
        @(negedge clk);
        goal_node = mk(v.goal);
        start_node_id = v.sid;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (v.poke) begin
                if (path_valid && !start) begin
                    start = 1'b1;
                    goal_node = mk(16'd9);
                    start_node_id = 16'd9;
                end else start = 1'b0;
            end
        end
        start = 1'b0;
        chk({v.name, ".done_seen"}, 32'(seen), 32'd1);
        chk({v.name, ".busy_in_done"}, 32'(busy), 32'd1);
        chk({v.name, ".err"}, 32'(err_code), 32'(v.err));
        @(negedge clk);
        chk({v.name, ".busy_after"}, 32'(busy), 32'd0);
        repeat (8) @(negedge clk);
        chk({v.name, ".busy_idle"}, 32'(busy), 32'd0);
        chk({v.name, ".len"}, 32'(got_id.size()), 32'(v.len));
        for (int i = 0; i < v.len && i < 4 && i < got_id.size(); i++) begin
            en = mk(v.ids[i]);
            chk($sformatf("%s.id%0d", v.name, i), 32'(got_id[i]), 32'(v.ids[i]));
            chk($sformatf("%s.x%0d", v.name, i), 32'(got_x[i]), 32'(en.x));
            chk($sformatf("%s.y%0d", v.name, i), 32'(got_y[i]), 32'(en.y));
            chk($sformatf("%s.last%0d", v.name, i), 32'(got_last[i]), 32'(i == v.len - 1));
        end
        chk({v.name, ".finds"}, 32'(pf_find_cnt), 32'(v.finds));
        chk({v.name, ".done_pulses"}, 32'(done_cnt), 32'd1);
        chk({v.name, ".valid_seen"}, 32'(valid_seen), 32'(v.len > 0));
        chk({v.name, ".stable"}, 32'(unstable), 32'd0);
        ready_toggle = 1'b0;
    endtask

    initial begin
        vec_t tv;
        bit seen;
        vecs[0] = '{name:"three_hop", goal:16'd5, sid:16'd1, mode:0, toggle:1'b0, poke:1'b0,
                    err:ERR_NONE, len:3, finds:2, ids:'{16'd1, 16'd3, 16'd5, 16'd0}};
        vecs[1] = '{name:"start_is_goal", goal:16'd7, sid:16'd7, mode:0, toggle:1'b0, poke:1'b0,
                    err:ERR_NONE, len:1, finds:0, ids:'{16'd7, 16'd0, 16'd0, 16'd0}};
        vecs[2] = '{name:"not_found", goal:16'd5, sid:16'd1, mode:1, toggle:1'b0, poke:1'b0,
                    err:ERR_NOT_FOUND, len:0, finds:1, ids:'{16'd0, 16'd0, 16'd0, 16'd0}};
        vecs[3] = '{name:"overflow", goal:16'd71, sid:16'd1, mode:2, toggle:1'b0, poke:1'b0,
                    err:ERR_OVERFLOW, len:0, finds:63, ids:'{16'd0, 16'd0, 16'd0, 16'd0}};
        vecs[4] = '{name:"backpressure", goal:16'd5, sid:16'd1, mode:0, toggle:1'b1, poke:1'b1,
                    err:ERR_NONE, len:3, finds:2, ids:'{16'd1, 16'd3, 16'd5, 16'd0}};

        repeat (3) @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err_code), 32'd0);
        chk("rst.valid", 32'(path_valid), 32'd0);
        chk("rst.find", 32'(pf_find), 32'd0);
        chk("rst.cur_node", 32'(pf_current_node != '0), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 5; k++) run_walk(vecs[k]);

        // reset while waiting on the finder, then a fresh walk
        mode = 0;
        pf_find_cnt = 0;
        @(negedge clk);
        goal_node = mk(16'd5);
        start_node_id = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (pf_find_cnt == 1) seen = 1'b1;
        end
        chk("midrst.reached_wait", 32'(seen), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.find", 32'(pf_find), 32'd0);
        chk("midrst.valid", 32'(path_valid), 32'd0);
        chk("midrst.cur_node", 32'(pf_current_node != '0), 32'd0);
        chk("midrst.err", 32'(err_code), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        run_walk(vecs[0]);

`ifdef BACKTRACK_TIMEOUT_EN
        tv = '{name:"timeout", goal:16'd5, sid:16'd1, mode:3, toggle:1'b0, poke:1'b0,
               err:ERR_TIMEOUT, len:0, finds:1, ids:'{16'd0, 16'd0, 16'd0, 16'd0}};
        run_walk(tv);
        chk("timeout.wait_cycles", 32'(done_cyc - find_cyc), 32'(TOUT + 1));
`else
        tv = vecs[0];
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
